// File: rtl/cpu_wb_master_if.sv
// Wishbone B4 classic bus between the CPU load/store master and the interconnect.
// Handshake: the master raises cyc+stb with adr/sel/we/dat_o stable and holds
// them until the slave answers with a single-cycle ack (done) or err (fault).
interface cpu_wb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   wb_adr_o;
    logic [DATA_W-1:0]   wb_dat_o;
    logic [DATA_W-1:0]   wb_dat_i;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic                wb_we_o;
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_ack_i;
    logic                wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/cpu_wb_master.sv
// Wishbone classic-cycle master for the OTTER CPU memory stage: lane selects,
// store replication, load extension, misalignment/illegal-request rejection,
// bus-error capture and an ACTIVE-cycle watchdog.
module cpu_wb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              sign,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        dbg_state,
    cpu_wb_master_if.master   wb
);
    localparam int SEL_W = DATA_W / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              sign_q;

    logic              req_one, req_both, misaligned, timed_out;
    logic [2:0]        align_mask;
    logic [SEL_W-1:0]  sel_calc;
    logic [DATA_W-1:0] dat_calc;
    logic [DATA_W-1:0] rd_shift, rd_ext;
    logic signed [DATA_W-1:0] rd_left;
    logic [6:0]        ext_sh;

    assign req_one   = mem_read ^ mem_write;
    assign req_both  = mem_read & mem_write;
    // Watchdog fires at the end of the TIMEOUT-th ACTIVE cycle.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Alignment check: low address bits covered by the access size must be zero.
    always_comb begin
        align_mask = 3'b000;
        case (size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = ((addr[2:0] & align_mask) != 3'b000) ||
                     ((size == 2'd3) && (DATA_W == 32));
    end

    // Byte-lane select and replicated store data for the incoming request.
    always_comb begin
        sel_calc = '0;
        dat_calc = data_out;
        case (size)
            2'd0: begin
                sel_calc = SEL_W'(1) << addr[OFF_W-1:0];
                dat_calc = {SEL_W{data_out[7:0]}};
            end
            2'd1: begin
                sel_calc = SEL_W'(2'b11) << addr[OFF_W-1:0];
                dat_calc = {(SEL_W/2){data_out[15:0]}};
            end
            2'd2: begin
                sel_calc = SEL_W'(4'hF) << addr[OFF_W-1:0];
                dat_calc = {(SEL_W/4){data_out[31:0]}};
            end
            default: begin
                sel_calc = '1;
                dat_calc = data_out;
            end
        endcase
    end

    // Load path: right-align the addressed lanes, then sign- or zero-extend
    // by pushing the field to the top and shifting it back down.
    always_comb begin
        rd_shift = wb.wb_dat_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext_sh = 7'(DATA_W - 8);
            2'd1:    ext_sh = 7'(DATA_W - 16);
            2'd2:    ext_sh = 7'(DATA_W - 32);
            default: ext_sh = 7'd0;
        endcase
        rd_left = rd_shift << ext_sh;
        if (sign_q) begin
            rd_ext = rd_shift & ({DATA_W{1'b1}} >> ext_sh);
        end else begin
            rd_ext = rd_left >>> ext_sh;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_both || (req_one && misaligned)) begin
                    state_d = S_RESP;
                end else if (req_one) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (wb.wb_err_i || wb.wb_ack_i || timed_out) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and ACTIVE-cycle counter (cleared whenever ACTIVE is left).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ACTIVE && state_d == S_ACTIVE) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Request latch on acceptance and result capture on completion.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            data_in <= '0;
            error   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && state_d == S_ACTIVE) begin
                adr_q  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                dat_q  <= dat_calc;
                sel_q  <= sel_calc;
                we_q   <= mem_write;
                off_q  <= addr[OFF_W-1:0];
                size_q <= size;
                sign_q <= sign;
            end
            if (state_q == S_IDLE && state_d == S_RESP) begin
                error   <= 1'b1;
                data_in <= '0;
            end
            if (state_q == S_ACTIVE && state_d == S_RESP) begin
                if (wb.wb_err_i || !wb.wb_ack_i) begin
                    error   <= 1'b1;
                    data_in <= '0;
                end else begin
                    error   <= 1'b0;
                    data_in <= rd_ext;
                end
            end
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = (state_q == S_ACTIVE);
    assign wb.wb_stb_o = (state_q == S_ACTIVE);
    assign busy        = (state_q == S_ACTIVE);
    assign done        = (state_q == S_RESP);
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_cpu_wb_master.sv
// Bench for cpu_wb_master (DATA_W=32, TIMEOUT=4): directed cases plus random
// load/store traffic checked against a byte-level reference model.
module tb_cpu_wb_master;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, sign;
    logic [1:0]  size;
    logic [31:0] addr, data_out, data_in;
    logic        busy, done, error;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_din = '0;
    logic        last_err = 1'b0;

    cpu_wb_master_if #(.ADDR_W(32), .DATA_W(32)) wb ();

    cpu_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .sign     (sign),
        .size     (size),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .dbg_state(dbg_state),
        .wb       (wb)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, lane picture and extension.
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s = '0;
        int off = a % 4;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(sz)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdat(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = '0;
        int off = a % 4;
        int n = nbytes(sz);
        for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(off+j) +: 8];
        if (!sg && v[8*n-1]) for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    // One CPU request. kind: 0 ack, 1 err, 2 ack+err, 3 silent slave.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d,
                           input int kind, input int dly, input logic [31:0] rdat);
        logic bad_req, on_bus, got_done;
        int   exp_cycles, cyc_cnt;
        logic [31:0] exp_din;
        bad_req = (rd && wr) || (sz == 2'd3) || (a % nbytes(sz) != 0);
        on_bus  = !bad_req;
        exp_cycles = !on_bus ? 0 : (kind == 3 ? TO : dly);
        exp_din = (on_bus && kind == 0) ? model_load(sz, sg, a, rdat) : 32'h0;
        exp_q.push_back(exp_din);

        @(negedge clk);
        check_val("hold_din", data_in, last_din);
        check_val("hold_err", error, last_err);
        mem_read = rd; mem_write = wr; size = sz; sign = sg; addr = a; data_out = d;
        wb.wb_dat_i = rdat;
        @(posedge clk);
        #1 mem_read = 1'b0; mem_write = 1'b0;

        cyc_cnt = 0; got_done = 1'b0;
        for (int k = 0; k < 30 && !got_done; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
            end else if (wb.wb_cyc_o) begin
                cyc_cnt++;
                check_val("stb", wb.wb_stb_o, 1'b1);
                check_val("busy", busy, 1'b1);
                check_val("sel", wb.wb_sel_o, model_sel(sz, a));
                check_val("adr", wb.wb_adr_o, a & ~32'h3);
                check_val("we", wb.wb_we_o, wr);
                if (wr) check_val("wdat", wb.wb_dat_o, model_wdat(sz, d));
                if (cyc_cnt == dly && kind != 3) begin
                    wb.wb_ack_i = (kind != 1);
                    wb.wb_err_i = (kind != 0);
                end
            end
        end
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0;
        check_val("done_seen", got_done, 1'b1);
        check_val("bus_cycles", cyc_cnt, exp_cycles);
        check_val("error", error, !(on_bus && kind == 0));
        check_val("data_in", data_in, exp_q.pop_front());
        check_val("cyc_off", wb.wb_cyc_o, 1'b0);
        check_val("busy_off", busy, 1'b0);
        last_din = exp_din;
        last_err = !(on_bus && kind == 0);
        @(negedge clk);
        check_val("done_pulse", done, 1'b0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int r, kind;
        logic rd, wr;

        // Reset.
        rst = 1'b1; mem_read = 0; mem_write = 0; sign = 0; size = 0; addr = 0; data_out = 0;
        wb.wb_dat_i = 0; wb.wb_ack_i = 0; wb.wb_err_i = 0;
        repeat (3) @(negedge clk);
        check_val("rst_cyc", wb.wb_cyc_o, 1'b0);
        check_val("rst_stb", wb.wb_stb_o, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_err", error, 1'b0);
        check_val("rst_din", data_in, 32'h0);
        check_val("rst_sel", wb.wb_sel_o, 4'h0);
        check_val("rst_we", wb.wb_we_o, 1'b0);
        rst = 1'b0;

        // Directed cases.
        run_txn(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF);
        run_txn(0, 1, 2'd0, 0, 32'h103, 32'h000000A5, 0, 1, 32'h0);
        run_txn(1, 0, 2'd1, 0, 32'h202, 32'h0, 0, 1, 32'h80011234);
        run_txn(1, 0, 2'd1, 1, 32'h202, 32'h0, 0, 3, 32'h80011234);
        run_txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 0, 1, 32'h12345678);
        run_txn(1, 0, 2'd3, 0, 32'h100, 32'h0, 0, 1, 32'h12345678);
        run_txn(1, 1, 2'd2, 0, 32'h100, 32'h0, 0, 1, 32'h12345678);
        run_txn(1, 0, 2'd2, 0, 32'h300, 32'h0, 3, 1, 32'h12345678);
        run_txn(1, 0, 2'd2, 0, 32'h304, 32'h0, 2, 2, 32'hCAFEF00D);
        run_txn(0, 1, 2'd1, 0, 32'h306, 32'h0000BEEF, 1, 1, 32'h0);
        run_txn(1, 0, 2'd0, 0, 32'h401, 32'h0, 0, TO, 32'h00F00000);

        // Reset during ACTIVE abandons the transaction without done.
        @(negedge clk);
        mem_read = 1; size = 2'd2; addr = 32'h40;
        @(posedge clk);
        #1 mem_read = 0;
        @(negedge clk);
        check_val("mid_cyc_on", wb.wb_cyc_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_cyc", wb.wb_cyc_o, 1'b0);
        check_val("mid_stb", wb.wb_stb_o, 1'b0);
        check_val("mid_busy", busy, 1'b0);
        check_val("mid_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_no_done", done, 1'b0);
        last_din = '0; last_err = 1'b0;
        run_txn(1, 0, 2'd2, 0, 32'h44, 32'h0, 0, 1, 32'h13572468);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            r  = $urandom_range(0, 9);
            rd = (r <= 4) || (r == 9);
            wr = (r >= 5);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            r  = $urandom_range(0, 9);
            kind = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
            run_txn(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, kind,
                    $urandom_range(1, TO), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
